// File: rtl/muldiv_unit.sv
// Iterative 64-bit multiply/divide unit for the execute stage: radix-2 shift-add multiply
// and restoring divide, one step per cycle, with stall/resp_valid handshake to the pipeline.
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            stall,
    output logic            resp_valid,
    output logic [XLEN-1:0] result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_UMULH = 3'd1;
    localparam logic [2:0] OP_SMULH = 3'd2;
    localparam logic [2:0] OP_UDIV  = 3'd3;
    localparam logic [2:0] OP_SDIV  = 3'd4;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    // Accept-time decode: signed ops work on magnitudes and fix the sign at the end.
    logic            w_is_div, w_signed, w_short, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_abs_a, w_abs_b;

    assign w_is_div = (req_op == OP_UDIV) || (req_op == OP_SDIV);
    assign w_signed = (req_op == OP_SMULH) || (req_op == OP_SDIV);
    assign w_a_neg  = w_signed & srca[XLEN-1];
    assign w_b_neg  = w_signed & srcb[XLEN-1];
    assign w_abs_a  = w_a_neg ? (~srca + XLEN'(1)) : srca;
    assign w_abs_b  = w_b_neg ? (~srcb + XLEN'(1)) : srcb;
    assign w_short  = (req_op > OP_SDIV) || (w_is_div && (srcb == '0));

    // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
    logic              w_op_div;
    logic [XLEN:0]     w_mul_hi;
    logic [2*XLEN-1:0] w_mul_acc;

    assign w_op_div  = (r_op == OP_UDIV) || (r_op == OP_SDIV);
    assign w_mul_hi  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc = {w_mul_hi, r_acc[XLEN-1:1]};

    // Divide: acc holds {remainder, dividend/quotient}; shift left and try to subtract.
    logic [XLEN:0]     w_shift, w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_div_acc;

    assign w_shift   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff    = w_shift - {1'b0, r_opnd};
    assign w_ge      = w_shift >= {1'b0, r_opnd};
    assign w_div_acc = {(w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

    logic [2*XLEN-1:0] w_next_acc, w_neg_acc;
    logic [XLEN-1:0]   w_final;
    logic              w_last;

    assign w_next_acc = w_op_div ? w_div_acc : w_mul_acc;
    assign w_neg_acc  = ~w_next_acc + (2*XLEN)'(1);
    assign w_last     = (r_cnt == CNT_W'(XLEN - 1));

    // NOTE: every path assigns w_final, so no latch is inferred for this mux.
    always_comb begin
        w_final = '0;
        case (r_op)
            OP_MUL:   w_final = w_next_acc[XLEN-1:0];
            OP_UMULH: w_final = w_next_acc[2*XLEN-1:XLEN];
            OP_SMULH: w_final = r_neg ? w_neg_acc[2*XLEN-1:XLEN] : w_next_acc[2*XLEN-1:XLEN];
            OP_UDIV:  w_final = w_next_acc[XLEN-1:0];
            OP_SDIV:  w_final = r_neg ? w_neg_acc[XLEN-1:0] : w_next_acc[XLEN-1:0];
            default:  w_final = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op  <= req_op;
                        r_neg <= w_a_neg ^ w_b_neg;
                        r_cnt <= '0;
                        if (w_short) begin
                            r_acc    <= '0;
                            r_result <= '0;
                            r_state  <= S_DONE;
                        end else begin
                            r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
                            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // A dropped request is a flush: abandon the op and keep the old result.
                    if (!req_valid) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_next_acc;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= w_final;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall      = ((r_state == S_IDLE) && req_valid) || (r_state == S_BUSY);
    assign resp_valid = (r_state == S_DONE);
    assign result     = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: drivers push expected results, a negedge monitor
// pops and compares on every resp_valid pulse.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [63:0] srca, srcb;
    logic        stall, resp_valid;
    logic [63:0] result;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .srca       (srca),
        .srcb       (srcb),
        .stall      (stall),
        .resp_valid (resp_valid),
        .result     (result)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    string       name_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    // Monitor: every response must be expected, in order, and never overlap stall.
    always @(negedge clk) begin
        if (resp_valid) begin
            check("resp_stall_exclusive", 64'(stall), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                automatic logic [63:0] e  = exp_q.pop_front();
                automatic string       nm = name_q.pop_front();
                check(nm, result, e);
            end
        end
    end

    // Issue one op and hold it until the response; counts stall cycles before resp_valid.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_stall,
                          input bit scramble);
        int n;
        bit seen;
        req_valid = 1'b1;
        req_op    = op;
        srca      = a;
        srcb      = b;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
            else if (stall) n++;
            @(posedge clk);
            #1;
            if (scramble && !seen) begin
                srca = {$urandom, $urandom};
                srcb = {$urandom, $urandom};
            end
        end
        check({nm, "_resp_seen"}, 64'(seen), 64'd1);
        check({nm, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    endtask

    localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INTMIN = 64'h8000_0000_0000_0000;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        srca      = '0;
        srcb      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_result", result, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul_max_x2",      3'd0, ALL1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
        run_op("umulh_max_max",   3'd1, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
        run_op("smulh_m1_x1",     3'd2, ALL1, 64'd1, ALL1, 65, 1'b0);
        run_op("smulh_neg_2p64",  3'd2, 64'hC000_0000_0000_0000, 64'd4, ALL1, 65, 1'b0);
        run_op("smulh_pos_2p64",  3'd2, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 65, 1'b0);
        run_op("umulh_2p65",      3'd1, INTMIN, 64'd4, 64'd2, 65, 1'b0);
        run_op("sdiv_m7_2",       3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
        run_op("sdiv_7_m2",       3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
        run_op("sdiv_intmin_m1",  3'd4, INTMIN, ALL1, INTMIN, 65, 1'b0);
        run_op("udiv_max_3",      3'd3, ALL1, 64'd3, 64'h5555_5555_5555_5555, 65, 1'b0);
        run_op("udiv_5_0",        3'd3, 64'd5, 64'd0, 64'd0, 1, 1'b0);
        run_op("sdiv_m5_0",       3'd4, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0, 1, 1'b0);
        run_op("invalid_op5",     3'd5, 64'd9, 64'd3, 64'd0, 1, 1'b0);
        run_op("invalid_op7",     3'd7, ALL1, ALL1, 64'd0, 1, 1'b0);
        run_op("mul_scrambled",   3'd0, 64'h1234, 64'h10, 64'h12340, 65, 1'b1);
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Flush at BUSY step 20: no response, result keeps the previous value.
        req_valid = 1'b1;
        req_op    = 3'd0;
        srca      = 64'd1000;
        srcb      = 64'd1000;
        @(posedge clk);
        #1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_still_busy", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        check("abort_stall_cleared", 64'(stall), 64'd0);
        check("abort_no_resp", 64'(resp_valid), 64'd0);
        check("abort_result_held", result, 64'h12340);
        repeat (3) @(posedge clk);
        #1;
        run_op("mul_3x4_after_abort", 3'd0, 64'd3, 64'd4, 64'd12, 65, 1'b0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset at BUSY step 30 clears everything including the held result.
        req_valid = 1'b1;
        req_op    = 3'd0;
        srca      = ALL1;
        srcb      = ALL1;
        @(posedge clk);
        #1;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midop_reset_stall", 64'(stall), 64'd0);
        check("midop_reset_resp_valid", 64'(resp_valid), 64'd0);
        check("midop_reset_result", result, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("b2b_udiv_100_7", 3'd3, 64'd100, 64'd7, 64'd14, 65, 1'b0);
        run_op("b2b_mul_6_7",    3'd0, 64'd6, 64'd7, 64'd42, 65, 1'b0);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
